// File: rtl/pattern_search_pkg.sv
// Shared types and reset-time defaults for the serial pattern-search controller.
package pattern_search_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StReport
  } state_e;

  // Default configuration restored by reset: detect "1010", overlapping, first hit ends search.
  localparam logic [15:0] DefaultPattern = 16'b1010;
  localparam int unsigned DefaultLen     = 4;
  localparam int unsigned DefaultTarget  = 1;

  // A zero length still compares one bit; lengths past the window width use the full window.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned max_len);
    if (len == 0) begin
      return 1;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Bit history shift register with a fill-depth counter and a length-masked pattern compare.
// The compare looks at the history as it will be once the incoming bit is shifted in, so a
// match is reported in the same cycle the matching bit is offered.
module pattern_window
  import pattern_search_pkg::*;
#(
  parameter int unsigned PatW = 8,
  parameter int unsigned LenW = $clog2(PatW) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            shift_i,
  input  logic            din_i,
  input  logic            clear_i,
  input  logic [LenW-1:0] len_i,
  input  logic [PatW-1:0] pattern_i,
  output logic            match_o
);

  localparam logic [LenW-1:0] DepthMax = LenW'(PatW);

  logic [PatW-1:0] hist_q, hist_d, hist_next, mask;
  logic [LenW-1:0] depth_q, depth_d, depth_next;

  // Next history, saturating depth, and the masked compare against the newest len bits.
  always_comb begin
    hist_next  = {hist_q[PatW-2:0], din_i};
    depth_next = (depth_q == DepthMax) ? DepthMax : depth_q + 1'b1;
    mask       = '0;
    for (int i = 0; i < PatW; i++) begin
      mask[i] = (LenW'(i) < len_i);
    end
    match_o = shift_i && (depth_next >= len_i) &&
              (((hist_next ^ pattern_i) & mask) == '0);

    // A clear on a shifting cycle (non-overlap match) keeps the bit but forgets the depth.
    if (shift_i) begin
      hist_d = hist_next;
    end else if (clear_i) begin
      hist_d = '0;
    end else begin
      hist_d = hist_q;
    end

    if (clear_i) begin
      depth_d = '0;
    end else if (shift_i) begin
      depth_d = depth_next;
    end else begin
      depth_d = depth_q;
    end
  end

  // History and depth registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q  <= '0;
      depth_q <= '0;
    end else begin
      hist_q  <= hist_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/pattern_search_ctrl.sv
// Sequenced pattern-search resource: latches a configuration, runs a search over qualified
// serial bits, counts matches and ends on a match target or a bit-window limit.
module pattern_search_ctrl
  import pattern_search_pkg::*;
#(
  parameter int unsigned PatW = 8,
  parameter int unsigned CntW = 16,
  parameter int unsigned LenW = $clog2(PatW) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic [PatW-1:0] cfg_pattern_i,
  input  logic [LenW-1:0] cfg_len_i,
  input  logic            cfg_overlap_i,
  input  logic [CntW-1:0] cfg_window_i,
  input  logic [CntW-1:0] cfg_target_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            din_i,
  input  logic            din_valid_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            hit_o,
  output logic            timeout_o,
  output logic            match_pulse_o,
  output logic [CntW-1:0] match_count_o,
  output logic [CntW-1:0] bit_count_o
);

  localparam logic [PatW-1:0] RstPattern = DefaultPattern[PatW-1:0];
  localparam logic [LenW-1:0] RstLen     = LenW'(DefaultLen);
  localparam logic [CntW-1:0] RstTarget  = CntW'(DefaultTarget);

  state_e          state_q, state_d;
  logic [PatW-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LenW-1:0] cfg_len_q, cfg_len_d;
  logic            cfg_overlap_q, cfg_overlap_d;
  logic [CntW-1:0] cfg_window_q, cfg_window_d;
  logic [CntW-1:0] cfg_target_q, cfg_target_d;
  logic [CntW-1:0] match_count_q, match_count_d;
  logic [CntW-1:0] bit_count_q, bit_count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic            timeout_q, timeout_d;
  logic            match_pulse_q, match_pulse_d;

  logic            start_go, consume, match, win_clear;
  logic            hit_term, to_term;
  logic [CntW-1:0] bit_cnt_inc, match_cnt_inc;

  // Per-bit events: a bit is consumed only in SEARCH and never on an aborting cycle.
  always_comb begin
    start_go      = (state_q == StIdle) && start_i;
    consume       = (state_q == StSearch) && din_valid_i && !abort_i;
    win_clear     = start_go || (match && !cfg_overlap_q);
    bit_cnt_inc   = (&bit_count_q) ? bit_count_q : bit_count_q + 1'b1;
    match_cnt_inc = (&match_count_q) ? match_count_q : match_count_q + 1'b1;
    hit_term      = match && (match_cnt_inc == cfg_target_q);
    to_term       = (cfg_window_q != '0) && (bit_cnt_inc == cfg_window_q);
  end

  pattern_window #(
    .PatW (PatW),
    .LenW (LenW)
  ) u_window (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .shift_i   (consume),
    .din_i     (din_i),
    .clear_i   (win_clear),
    .len_i     (cfg_len_q),
    .pattern_i (cfg_pattern_q),
    .match_o   (match)
  );

  // FSM next state, configuration latch, counters and status flags.
  always_comb begin
    state_d       = state_q;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_overlap_d = cfg_overlap_q;
    cfg_window_d  = cfg_window_q;
    cfg_target_d  = cfg_target_q;
    match_count_d = match_count_q;
    bit_count_d   = bit_count_q;
    hit_d         = hit_q;
    timeout_d     = timeout_q;
    done_d        = 1'b0;
    match_pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Written before start is acted on, so a same-cycle start sees the new values.
        if (cfg_we_i) begin
          cfg_pattern_d = cfg_pattern_i;
          cfg_len_d     = LenW'(clamp_len(32'(cfg_len_i), PatW));
          cfg_overlap_d = cfg_overlap_i;
          cfg_window_d  = cfg_window_i;
          cfg_target_d  = (cfg_target_i == '0) ? CntW'(1) : cfg_target_i;
        end
        if (start_go) begin
          state_d       = StSearch;
          match_count_d = '0;
          bit_count_d   = '0;
          hit_d         = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      StSearch: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (consume) begin
          bit_count_d = bit_cnt_inc;
          if (match) begin
            match_count_d = match_cnt_inc;
            match_pulse_d = 1'b1;
          end
          // Reaching the target takes priority over an exhausted window on the same bit.
          if (hit_term) begin
            state_d = StReport;
            hit_d   = 1'b1;
            done_d  = 1'b1;
          end else if (to_term) begin
            state_d   = StReport;
            timeout_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StSearch);
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cfg_pattern_q <= RstPattern;
      cfg_len_q     <= RstLen;
      cfg_overlap_q <= 1'b1;
      cfg_window_q  <= '0;
      cfg_target_q  <= RstTarget;
      match_count_q <= '0;
      bit_count_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      timeout_q     <= 1'b0;
      match_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_overlap_q <= cfg_overlap_d;
      cfg_window_q  <= cfg_window_d;
      cfg_target_q  <= cfg_target_d;
      match_count_q <= match_count_d;
      bit_count_q   <= bit_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hit_q         <= hit_d;
      timeout_q     <= timeout_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hit_o         = hit_q;
  assign timeout_o     = timeout_q;
  assign match_pulse_o = match_pulse_q;
  assign match_count_o = match_count_q;
  assign bit_count_o   = bit_count_q;

endmodule

// File: doc/pattern_search_ctrl.md
# pattern_search_ctrl

Programmable serial pattern-search controller. It accepts a start command, steps a configurable bit-pattern matcher over a qualified serial bit stream, counts matches, and ends the search on a match-count target or a bit-window limit. It reports done and status to the requesting logic. It sits between a serial receive path and control logic, and generalises the fixed Mealy "1010" detector into a configurable, sequenced search resource.

## Interface
- PAT_W, 8: maximum pattern length in bits (2..16).
- CNT_W, 16: width of the window, target and count registers.
- LEN_W, $clog2(PAT_W)+1: width of cfg_len (derived).

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  latch all cfg_* inputs; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the oldest bit, bit 0 the newest.
- cfg_len  in  LEN_W  pattern length; 0 is treated as 1, values > PAT_W as PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_window  in  CNT_W  number of bits to examine; 0 = unlimited.
- cfg_target  in  CNT_W  number of matches that ends the search; 0 is treated as 1.
- start  in  1  begins a search; honoured only in IDLE.
- abort  in  1  cancels a search in progress.
- din  in  1  serial data bit.
- din_valid  in  1  din qualifier; one bit is consumed per valid cycle.
- busy  out  1  high in SEARCH.
- done  out  1  one-cycle pulse when a search ends normally.
- hit  out  1  last search reached the target; held until the next start.
- timeout  out  1  last search exhausted the window; held until the next start.
- match_pulse  out  1  one-cycle pulse, registered, once per match.
- match_count  out  CNT_W  matches found in the current or last search.
- bit_count  out  CNT_W  valid bits consumed in the current or last search.

## Operation
- States: IDLE, SEARCH, REPORT.
- IDLE:
  - cfg_we latches the configuration.
  - start moves to SEARCH.
  - If cfg_we and start occur in the same cycle, the search uses the newly written configuration.
  - start clears match_count, bit_count, hit, timeout and the matcher history.
- SEARCH, on each din_valid:
  - Shift din into the history and increment bit_count.
  - Match when history depth ≥ len and the last len bits equal cfg_pattern[len-1:0].
  - On a match, increment match_count and pulse match_pulse.
  - If cfg_overlap=0, a match clears the history depth, so the next match needs len fresh bits.
- Termination is evaluated on the same bit:
  - If the new match_count equals the target, go to REPORT with hit=1.
  - Otherwise, if the new bit_count equals a nonzero window, go to REPORT with timeout=1.
  - If both conditions occur on the same bit, hit wins and timeout stays 0.
- Unlimited window: bit_count saturates at all-ones and no timeout occurs.
- REPORT: pulse done for one cycle, then return to IDLE.
- abort in SEARCH returns to IDLE on the next edge:
  - done is not pulsed; hit and timeout stay 0.
  - match_count and bit_count hold their values.
  - If abort coincides with a terminating bit, abort wins.
- start while busy, and cfg_we outside IDLE, are ignored.
- din is ignored outside SEARCH.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Configuration: pattern 4'b1010 (upper bits 0), len 4, overlap 1, window 0, target 1.
- start is sampled on edge N; busy=1 from N+1 and the first bit is accepted at N+1.
- match_pulse and match_count update on the edge that consumes the matching bit, so they are visible the cycle after that din_valid.
- On the terminating bit, sampled at edge M:
  - busy=0 and done=1 from M+1 (REPORT).
  - State is IDLE from M+2; the next start is accepted at M+2.
- An asynchronous reset assertion mid-search immediately forces IDLE, zeroes outputs, and restores the default configuration.

## Structure
- Shared package pattern_search_pkg:
  - State enum.
  - Default pattern, length and target constants.
- Sub-module pattern_window:
  - PAT_W shift register plus history-depth counter.
  - Combinational masked compare.
  - Inputs: shift, clear, len, pattern. Output: match.
- Top level holds the FSM, configuration registers, counters and status flags.

## Test plan
- Default config after reset; start, stream 1,0,1,0 valid → match_pulse after the 4th bit, done next cycle, hit=1, match_count=1, bit_count=4.
- Pattern 1010, target 3, overlap=1; stream 1010101010 → matches at bits 4, 6, 8; done after bit 8. With overlap=0 and target 2, matches at bits 4 and 8 only.
- Window 6, stream 111111 → timeout=1, hit=0, done after bit 6, bit_count=6, match_count=0.
- Window 4, target 1, stream 1010 → hit=1, timeout=0 (hit wins); din_valid gaps between bits do not change the result.
- Abort after 2 bits → busy drops, no done, bit_count=2. start during SEARCH is ignored. cfg_we during SEARCH does not change the pattern.
- Assert rst after 3 bits of a search → outputs 0 immediately and configuration returns to defaults; a following start with 1010 hits.
